regfile_wb: RTL and testbench

REGFILE_WB -- requirements
Module: regfile_wb

---
 rtl/core_pkg.sv | 13 +
 rtl/wb_mult_queue.sv | 90 +++++++++
 rtl/regfile_wb.sv | 141 ++++++++++++++
 tb/tb_regfile_wb.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core widths and the MULT writeback queue entry layout.
package core_pkg;

    localparam int XLEN = 32;
    localparam int RW   = 5;

    typedef struct packed {
        logic            valid;
        logic [RW-1:0]   rd;
        logic [XLEN-1:0] data;
    } wbq_entry_t;

endpackage

// File: rtl/wb_mult_queue.sv
// FIFO of MULT writebacks that lost arbitration to EXE, with kill-by-rd so
// a younger EXE write to the same register is never overwritten later.
module wb_mult_queue
    import core_pkg::*;
#(
    parameter int QDEPTH = 2,
    parameter int CW     = $clog2(QDEPTH + 1)
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            push,
    input  logic [RW-1:0]   push_rd,
    input  logic [XLEN-1:0] push_data,
    input  logic            pop,
    input  logic            kill,
    input  logic [RW-1:0]   kill_rd,
    output wbq_entry_t      head,
    output wbq_entry_t      view [QDEPTH],
    output logic [CW-1:0]   count
);

    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

    wbq_entry_t    mem_r [QDEPTH];
    logic [PW-1:0] head_r;
    logic [PW-1:0] tail_r;
    logic [CW-1:0] count_r;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        if (p == PW'(QDEPTH - 1)) begin
            return {PW{1'b0}};
        end else begin
            return p + PW'(1);
        end
    endfunction

    // Slot holding the entry 'age' positions behind the head (0 = oldest).
    function automatic logic [PW-1:0] age_slot(input logic [PW-1:0] base, input int unsigned age);
        logic [PW:0] s;
        s = {1'b0, base} + (PW + 1)'(age);
        if (s >= (PW + 1)'(QDEPTH)) begin
            s = s - (PW + 1)'(QDEPTH);
        end else begin
            s = s;
        end
        return s[PW-1:0];
    endfunction

    // Queue storage: kill, then pop, then push so a full-queue push/pop can reuse the head slot.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < QDEPTH; i++) begin
                mem_r[i] <= '0;
            end
            head_r  <= {PW{1'b0}};
            tail_r  <= {PW{1'b0}};
            count_r <= {CW{1'b0}};
        end else begin
            for (int i = 0; i < QDEPTH; i++) begin
                if (kill && mem_r[i].valid && (mem_r[i].rd == kill_rd)) begin
                    mem_r[i].valid <= 1'b0;
                end
            end
            if (pop) begin
                mem_r[head_r].valid <= 1'b0;
                head_r              <= next_ptr(head_r);
            end
            if (push) begin
                mem_r[tail_r] <= '{valid: 1'b1, rd: push_rd, data: push_data};
                tail_r        <= next_ptr(tail_r);
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Age-ordered view for the read bypass; empty slots already have valid cleared.
    always_comb begin
        for (int i = 0; i < QDEPTH; i++) begin
            view[i] = mem_r[age_slot(head_r, i)];
        end
    end

    assign head  = mem_r[head_r];
    assign count = count_r;

endmodule

// File: rtl/regfile_wb.sv
// 31x32 register file with EXE and MULT writeback ports; MULT writes that
// collide with EXE are queued and drained on EXE-idle cycles.
module regfile_wb
    import core_pkg::*;
#(
    parameter int QDEPTH = 2
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            EXE_reg_wr,
    input  logic [RW-1:0]   EXE_reg_rd,
    input  logic [XLEN-1:0] EXE_reg_data,
    input  logic            MULT_reg_wr,
    input  logic [RW-1:0]   MULT_reg_rd,
    input  logic [XLEN-1:0] MULT_reg_data,
    input  logic [RW-1:0]   rs1_index,
    input  logic [RW-1:0]   rs2_index,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            mult_stall,
    output logic            q_ovf
);

    localparam int CW = $clog2(QDEPTH + 1);

    logic [XLEN-1:0] regs_r [1:31];
    logic            q_ovf_r;

    logic            exe_we_s, mult_req_s, mult_direct_s;
    logic            q_empty_s, q_full_s, pop_s, push_try_s, push_s, ovf_set_s;
    logic            wr_en_s;
    logic [RW-1:0]   wr_rd_s;
    logic [XLEN-1:0] wr_data_s;
    logic [CW-1:0]   count_s;
    wbq_entry_t      head_s;
    wbq_entry_t      view_s [QDEPTH];
    logic [RW-1:0]   rd_idx_s [2];
    logic [XLEN-1:0] rd_val_s [2];

    assign exe_we_s      = EXE_reg_wr  && (EXE_reg_rd  != 5'd0);
    assign mult_req_s    = MULT_reg_wr && (MULT_reg_rd != 5'd0);
    assign q_empty_s     = (count_s == {CW{1'b0}});
    assign q_full_s      = (count_s == CW'(QDEPTH));
    // An invalidated head costs no array write, so it may drain under EXE.
    assign pop_s         = !q_empty_s && (!head_s.valid || !exe_we_s);
    assign mult_direct_s = mult_req_s && !exe_we_s && q_empty_s;
    // A MULT write superseded by a same-cycle EXE write to that rd is already stale.
    assign push_try_s    = mult_req_s && !mult_direct_s && !(exe_we_s && (EXE_reg_rd == MULT_reg_rd));
    assign push_s        = push_try_s && (!q_full_s || pop_s);
    assign ovf_set_s     = push_try_s && q_full_s && !pop_s;

    wb_mult_queue #(.QDEPTH(QDEPTH), .CW(CW)) u_queue (
        .clk       (clk),
        .rstn      (rstn),
        .push      (push_s),
        .push_rd   (MULT_reg_rd),
        .push_data (MULT_reg_data),
        .pop       (pop_s),
        .kill      (exe_we_s),
        .kill_rd   (EXE_reg_rd),
        .head      (head_s),
        .view      (view_s),
        .count     (count_s)
    );

    // Single array write port arbitration: EXE, then queue head, then direct MULT.
    always_comb begin
        wr_en_s   = 1'b0;
        wr_rd_s   = 5'd0;
        wr_data_s = 32'd0;
        if (exe_we_s) begin
            wr_en_s   = 1'b1;
            wr_rd_s   = EXE_reg_rd;
            wr_data_s = EXE_reg_data;
        end else if (pop_s && head_s.valid) begin
            wr_en_s   = 1'b1;
            wr_rd_s   = head_s.rd;
            wr_data_s = head_s.data;
        end else if (mult_direct_s) begin
            wr_en_s   = 1'b1;
            wr_rd_s   = MULT_reg_rd;
            wr_data_s = MULT_reg_data;
        end else begin
            wr_en_s   = 1'b0;
        end
    end

    // Register array storage.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 1; i < 32; i++) begin
                regs_r[i] <= 32'd0;
            end
        end else if (wr_en_s) begin
            regs_r[wr_rd_s] <= wr_data_s;
        end
    end

    // Sticky record that a MULT writeback was dropped.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q_ovf_r <= 1'b0;
        end else if (ovf_set_s) begin
            q_ovf_r <= 1'b1;
        end
    end

    assign rd_idx_s[0] = rs1_index;
    assign rd_idx_s[1] = rs2_index;

    // Read bypass; the queue scan runs oldest to newest so the newest match wins.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            logic            q_hit;
            logic [XLEN-1:0] q_data;
            q_hit  = 1'b0;
            q_data = 32'd0;
            for (int i = 0; i < QDEPTH; i++) begin
                q_data = (view_s[i].valid && (view_s[i].rd == rd_idx_s[p])) ? view_s[i].data : q_data;
                q_hit  = q_hit | (view_s[i].valid && (view_s[i].rd == rd_idx_s[p]));
            end
            if (rd_idx_s[p] == 5'd0) begin
                rd_val_s[p] = 32'd0;
            end else if (exe_we_s && (EXE_reg_rd == rd_idx_s[p])) begin
                rd_val_s[p] = EXE_reg_data;
            end else if (mult_req_s && (MULT_reg_rd == rd_idx_s[p])) begin
                rd_val_s[p] = MULT_reg_data;
            end else if (q_hit) begin
                rd_val_s[p] = q_data;
            end else begin
                rd_val_s[p] = regs_r[rd_idx_s[p]];
            end
        end
    end

    assign rs1_data   = rd_val_s[0];
    assign rs2_data   = rd_val_s[1];
    assign mult_stall = q_full_s;
    assign q_ovf      = q_ovf_r;

endmodule

// File: tb/tb_regfile_wb.sv
// Directed vector bench for regfile_wb: one table row per clock cycle, plus
// a hand-written queue-priority and mid-operation reset sequence.
module tb_regfile_wb;

    logic        clk = 1'b0;
    logic        rstn;
    logic        exe_wr, mult_wr;
    logic [4:0]  exe_rd, mult_rd, rs1, rs2;
    logic [31:0] exe_d, mult_d, rs1_d, rs2_d;
    logic        stall, ovf;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    regfile_wb #(.QDEPTH(2)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .EXE_reg_wr    (exe_wr),
        .EXE_reg_rd    (exe_rd),
        .EXE_reg_data  (exe_d),
        .MULT_reg_wr   (mult_wr),
        .MULT_reg_rd   (mult_rd),
        .MULT_reg_data (mult_d),
        .rs1_index     (rs1),
        .rs2_index     (rs2),
        .rs1_data      (rs1_d),
        .rs2_data      (rs2_d),
        .mult_stall    (stall),
        .q_ovf         (ovf)
    );

    typedef struct {
        logic        ew;
        logic [4:0]  erd;
        logic [31:0] ed;
        logic        mw;
        logic [4:0]  mrd;
        logic [31:0] md;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [31:0] x1;
        logic [31:0] x2;
        logic        xs;
        logic        xo;
    } vec_t;

    vec_t vt [20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic ew, input logic [4:0] erd, input logic [31:0] ed,
                         input logic mw, input logic [4:0] mrd, input logic [31:0] md,
                         input logic [4:0] r1, input logic [4:0] r2);
        exe_wr = ew;  exe_rd = erd;  exe_d = ed;
        mult_wr = mw; mult_rd = mrd; mult_d = md;
        rs1 = r1;     rs2 = r2;
    endtask

    initial begin
        //          ew    erd    ed            mw    mrd    md            r1     r2     x1            x2            xs    xo
        vt[0]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd5,  5'd6,  32'h0,        32'h0,        1'b0, 1'b0};
        vt[1]  = '{1'b1, 5'd5,  32'h11,       1'b0, 5'd0,  32'h0,        5'd5,  5'd6,  32'h11,       32'h0,        1'b0, 1'b0};
        vt[2]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd6,  32'h22,       5'd5,  5'd6,  32'h11,       32'h22,       1'b0, 1'b0};
        vt[3]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd5,  5'd6,  32'h11,       32'h22,       1'b0, 1'b0};
        vt[4]  = '{1'b1, 5'd3,  32'hA,        1'b1, 5'd4,  32'hB,        5'd4,  5'd3,  32'hB,        32'hA,        1'b0, 1'b0};
        vt[5]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd4,  5'd3,  32'hB,        32'hA,        1'b0, 1'b0};
        vt[6]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd4,  5'd3,  32'hB,        32'hA,        1'b0, 1'b0};
        vt[7]  = '{1'b1, 5'd8,  32'h8,        1'b1, 5'd7,  32'h1,        5'd7,  5'd8,  32'h1,        32'h8,        1'b0, 1'b0};
        vt[8]  = '{1'b1, 5'd7,  32'h2,        1'b0, 5'd0,  32'h0,        5'd7,  5'd8,  32'h2,        32'h8,        1'b0, 1'b0};
        vt[9]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd7,  5'd8,  32'h2,        32'h8,        1'b0, 1'b0};
        vt[10] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd7,  5'd4,  32'h2,        32'hB,        1'b0, 1'b0};
        vt[11] = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd0,  32'h0,        32'h0,        1'b0, 1'b0};
        vt[12] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd0,  5'd7,  32'h0,        32'h2,        1'b0, 1'b0};
        vt[13] = '{1'b1, 5'd9,  32'h90,       1'b1, 5'd10, 32'hA0,       5'd10, 5'd9,  32'hA0,       32'h90,       1'b0, 1'b0};
        vt[14] = '{1'b1, 5'd9,  32'h91,       1'b1, 5'd11, 32'hB0,       5'd10, 5'd11, 32'hA0,       32'hB0,       1'b0, 1'b0};
        vt[15] = '{1'b1, 5'd9,  32'h92,       1'b1, 5'd12, 32'hC0,       5'd11, 5'd9,  32'hB0,       32'h92,       1'b1, 1'b0};
        vt[16] = '{1'b1, 5'd9,  32'h93,       1'b0, 5'd0,  32'h0,        5'd12, 5'd10, 32'h0,        32'hA0,       1'b1, 1'b1};
        vt[17] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd12, 5'd9,  32'h0,        32'h93,       1'b1, 1'b1};
        vt[18] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd10, 5'd11, 32'hA0,       32'hB0,       1'b0, 1'b1};
        vt[19] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd11, 5'd12, 32'hB0,       32'h0,        1'b0, 1'b1};

        rstn = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            drive(vt[i].ew, vt[i].erd, vt[i].ed, vt[i].mw, vt[i].mrd, vt[i].md, vt[i].r1, vt[i].r2);
            #1;
            chk($sformatf("row%0d rs1", i), rs1_d, vt[i].x1);
            chk($sformatf("row%0d rs2", i), rs2_d, vt[i].x2);
            chk($sformatf("row%0d stall", i), {31'd0, stall}, {31'd0, vt[i].xs});
            chk($sformatf("row%0d q_ovf", i), {31'd0, ovf}, {31'd0, vt[i].xo});
        end

        // Two queued writes to x13: newest must win; then reset with the queue full.
        @(negedge clk);
        drive(1'b1, 5'd14, 32'h5, 1'b1, 5'd13, 32'h31, 5'd13, 5'd14);
        @(negedge clk);
        drive(1'b1, 5'd14, 32'h6, 1'b1, 5'd13, 32'h32, 5'd13, 5'd14);
        #1;
        chk("q1 rs1 mult bypass", rs1_d, 32'h32);
        @(negedge clk);
        drive(1'b1, 5'd14, 32'h7, 1'b0, 5'd0, 32'h0, 5'd13, 5'd14);
        #1;
        chk("q2 rs1 newest entry", rs1_d, 32'h32);
        chk("q2 rs2 exe bypass", rs2_d, 32'h7);
        chk("q2 stall", {31'd0, stall}, 32'd1);
        chk("q2 q_ovf sticky", {31'd0, ovf}, 32'd1);

        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd13, 5'd5);
        rstn = 1'b0;
        #1;
        chk("rst rs1 x13", rs1_d, 32'h0);
        chk("rst rs2 x5", rs2_d, 32'h0);
        chk("rst stall", {31'd0, stall}, 32'd0);
        chk("rst q_ovf", {31'd0, ovf}, 32'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd13, 5'd14);
        #1;
        chk("post-rst rs1 x13", rs1_d, 32'h0);
        chk("post-rst rs2 x14", rs2_d, 32'h0);
        chk("post-rst stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        #1;
        chk("post-rst drain x13", rs1_d, 32'h0);
        chk("post-rst q_ovf", {31'd0, ovf}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
